inv_pipe: RTL and testbench
===========================

INV_PIPE -- requirements
Module: inv_pipe

Interface
REQ-001 Parameter WIDTH, default 4: data width of A_in, mask and A_out.
REQ-002 Parameter DEPTH, default 2: output buffer entries; power of two, at least 2.
REQ-003 Parameter CNT_W, default 8: width of the delivered-word counter.
REQ-004 clk  input  1: single clock, all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, synchronous, active-low.
REQ-006 A_in  input  WIDTH: operand word.
REQ-007 mode  input  2: operation select, sampled with A_in: 00 PASS, 01 INV, 10 MASK_INV, 11 NEG.
REQ-008 mask  input  WIDTH: per-bit invert enable, used only in MASK_INV.
REQ-009 in_valid  input  1: A_in, mode and mask are valid this cycle.
REQ-010 in_ready  output  1: block accepts a word this cycle.
REQ-011 A_out  output  WIDTH: result at the buffer head.
REQ-012 out_valid  output  1: A_out holds a valid result.
REQ-013 out_ready  input  1: consumer takes A_out this cycle.
REQ-014 count  output  CNT_W: number of words delivered, modulo 2^CNT_W.

Function
REQ-015 Accept (push) SHALL occur exactly when in_valid and in_ready are both 1 at a rising edge.
REQ-016 Result per mode: PASS gives A_in. INV gives ~A_in. MASK_INV gives A_in XOR mask. NEG gives (~A_in + 1) truncated to WIDTH bits, carry discarded.
REQ-017 The result SHALL be computed from the inputs present at the accept edge and written into the buffer tail.
REQ-018 Buffer SHALL be FIFO-ordered, DEPTH entries, with wrap-around read and write pointers and an occupancy count of 0..DEPTH.
REQ-019 in_ready SHALL equal (occupancy < DEPTH), registered-state-derived, with no combinational path from out_ready.
REQ-020 out_valid SHALL equal (occupancy > 0).
REQ-021 A_out SHALL equal the head entry when out_valid is 1, and all-zeros otherwise.
REQ-022 Pop SHALL occur exactly when out_valid and out_ready are both 1 at a rising edge.
REQ-023 Latency: a word accepted into an empty buffer at edge N SHALL appear on A_out with out_valid=1 after edge N; no same-cycle bypass.
REQ-024 Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged, both pointers advance.
REQ-025 When full, in_ready=0 and in_valid is ignored, even if a pop occurs in the same cycle; in_ready returns to 1 the cycle after the pop.
REQ-026 When empty, out_ready is ignored, with no pointer or count change.
REQ-027 A_out and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 count SHALL increment by 1 on each pop and wrap from 2^CNT_W-1 to 0, with no saturation or flag.
REQ-029 An out-of-range mode cannot occur, since all four codes are defined.

Reset
REQ-030 When rst_n=0 at a rising edge: occupancy=0, pointers=0, count=0; out_valid=0, A_out=0 and in_ready=1 after that edge.
REQ-031 Reset SHALL override a push or pop in the same cycle. Reset mid-operation discards all buffered words.
REQ-032 Buffer storage contents need not be cleared, since they are invisible while out_valid=0.

Verification (WIDTH=4, DEPTH=2, CNT_W=8)
REQ-033 Modes, out_ready=1: push A_in=4'b0011 with each mode, mask=4'b0101 -> A_out = 0011, 1100, 0110, 1101 on consecutive cycles; count = 4.
REQ-034 NEG boundaries: A_in=0000 -> 0000. A_in=1000 -> 1000. A_in=1111 -> 0001.
REQ-035 Backpressure, out_ready=0: push 0001 then 0010 -> in_ready=0 after the second push; the third word is not accepted. Raise out_ready -> 1110 then 1101 in order, with INV mode.
REQ-036 Full plus simultaneous events: when full, hold out_ready=1 and in_valid=1 -> no push in the pop cycle; push in the next cycle; order preserved.
REQ-037 Count wrap: 256 pops -> count returns to 0 on the 256th pop.
REQ-038 Reset mid-stream with 2 words buffered: rst_n=0 for one edge -> out_valid=0, A_out=0000, count=0, in_ready=1; the next pushed word is the first output.

Source files
------------

// File: rtl/inv_pipe.sv
// Operand transform stage (pass / invert / masked invert / negate) feeding a
// small FIFO output buffer with valid/ready handshakes and a delivered-word counter.
module inv_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A_in,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] mask,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] A_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        MODE_PASS     = 2'b00,
        MODE_INV      = 2'b01,
        MODE_MASK_INV = 2'b10,
        MODE_NEG      = 2'b11
    } mode_e;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;

    // in_ready depends only on registered occupancy, so out_ready never reaches it.
    assign in_ready  = (occ_q < OCC_FULL);
    assign out_valid = (occ_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign A_out     = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        result = A_in;
        case (mode_e'(mode))
            MODE_PASS:     result = A_in;
            MODE_INV:      result = ~A_in;
            MODE_MASK_INV: result = A_in ^ mask;
            MODE_NEG:      result = (~A_in) + WIDTH'(1);
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            count_q  <= count_d;
        end
    end

    // NOTE: buffer storage is deliberately not reset; stale entries are masked by out_valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= result;
    end

endmodule

// File: tb/tb_inv_pipe.sv
// Directed self-checking bench for inv_pipe at WIDTH=4, DEPTH=2, CNT_W=8.
module tb_inv_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] A_in;
    logic [1:0] mode;
    logic [3:0] mask;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A_out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] count;

    int n_cmp  = 0;
    int n_fail = 0;

    inv_pipe #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A_in      (A_in),
        .mode      (mode),
        .mask      (mask),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A_out     (A_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge; outputs are then sampled half a period later.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [1:0] m, input logic r);
        in_valid  = v;
        A_in      = a;
        mode      = m;
        out_ready = r;
    endtask

    initial begin
        logic [3:0] mode_exp [4];
        logic [3:0] neg_in   [3];
        logic [3:0] neg_exp  [3];
        mode_exp = '{4'b0011, 4'b1100, 4'b0110, 4'b1101};
        neg_in   = '{4'b0000, 4'b1000, 4'b1111};
        neg_exp  = '{4'b0000, 4'b1000, 4'b0001};

        rst_n = 1'b0;
        mask  = 4'b0000;
        drive(1'b0, 4'h0, 2'b00, 1'b0);
        @(negedge clk);
        cyc();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_A_out",     32'(A_out),     32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_count",     32'(count),     32'd0);
        rst_n = 1'b1;
        cyc();

        // All four modes, consumer always ready: one result per cycle.
        mask = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'b0011, 2'(i), 1'b1);
            cyc();
            check($sformatf("mode%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("mode%0d_A_out", i), 32'(A_out), 32'(mode_exp[i]));
        end
        drive(1'b0, 4'h0, 2'b00, 1'b1);
        cyc();
        check("modes_count", 32'(count), 32'd4);
        check("modes_drained", 32'(out_valid), 32'd0);

        // NEG boundaries.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, neg_in[i], 2'b11, 1'b1);
            cyc();
            check($sformatf("neg%0d_A_out", i), 32'(A_out), 32'(neg_exp[i]));
        end
        drive(1'b0, 4'h0, 2'b00, 1'b1);
        cyc();
        check("neg_count", 32'(count), 32'd7);

        // Backpressure with INV: third word must be refused.
        drive(1'b1, 4'b0001, 2'b01, 1'b0);
        cyc();
        check("bp_ready_after1", 32'(in_ready), 32'd1);
        drive(1'b1, 4'b0010, 2'b01, 1'b0);
        cyc();
        check("bp_ready_full", 32'(in_ready), 32'd0);
        drive(1'b1, 4'b0100, 2'b01, 1'b0);
        cyc();
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_head_stable", 32'(A_out), 32'b1110);
        drive(1'b0, 4'h0, 2'b01, 1'b1);
        cyc();
        check("bp_second", 32'(A_out), 32'b1101);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        cyc();
        check("bp_third_refused", 32'(out_valid), 32'd0);
        check("bp_count", 32'(count), 32'd9);

        // Full with simultaneous push attempt and pop: push only lands next cycle.
        drive(1'b1, 4'h5, 2'b00, 1'b0);
        cyc();
        drive(1'b1, 4'h6, 2'b00, 1'b0);
        cyc();
        check("full_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 4'h7, 2'b00, 1'b1);
        cyc();
        check("full_pop_head", 32'(A_out), 32'h6);
        check("full_no_push", 32'(in_ready), 32'd1);
        cyc();
        check("full_next_push", 32'(A_out), 32'h7);
        check("full_next_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 4'h0, 2'b00, 1'b1);
        cyc();
        check("full_drained", 32'(out_valid), 32'd0);
        check("full_count", 32'(count), 32'd12);

        // Stream to the counter wrap: 243 pops reach 255, one more wraps to 0.
        for (int i = 0; i < 244; i++) begin
            drive(1'b1, 4'(i), 2'b00, 1'b1);
            cyc();
        end
        check("wrap_count_255", 32'(count), 32'd255);
        check("wrap_last_data", 32'(A_out), 32'h3);
        drive(1'b0, 4'h0, 2'b00, 1'b1);
        cyc();
        check("wrap_count_0", 32'(count), 32'd0);

        // Reset mid-stream with two words buffered, overriding push and pop.
        drive(1'b1, 4'h9, 2'b00, 1'b1);
        cyc();
        drive(1'b0, 4'h0, 2'b00, 1'b1);
        cyc();
        check("mid_count_pre", 32'(count), 32'd1);
        drive(1'b1, 4'hA, 2'b00, 1'b0);
        cyc();
        drive(1'b1, 4'hB, 2'b00, 1'b0);
        cyc();
        check("mid_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        drive(1'b1, 4'hC, 2'b00, 1'b1);
        cyc();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_A_out", 32'(A_out), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        drive(1'b1, 4'b0011, 2'b01, 1'b0);
        cyc();
        check("mid_first_valid", 32'(out_valid), 32'd1);
        check("mid_first_data", 32'(A_out), 32'b1100);
        drive(1'b0, 4'h0, 2'b00, 1'b1);
        cyc();
        check("mid_final_empty", 32'(out_valid), 32'd0);
        check("mid_final_count", 32'(count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
